mode_key_driver: RTL and testbench
==================================

# mode_key_driver

Generates key-press pulses on a `key` bus so that a downstream toggle-per-press mode register reaches a requested mode. The block is the transmitting end of the key/mode interface: a controller hands it a target mode, and it emits one clean rising-edge pulse per mode bit that must flip. It keeps a shadow copy of the downstream mode and sits between a sequencer or test controller and the key inputs of the mode register.

## Interface
- `WIDTH`, 2: number of key/mode bits.
- `PULSE_CYCLES`, 4: key high time in clk cycles; must be ≥ 1.
- `GAP_CYCLES`, 4: key low time after each pulse in clk cycles; must be ≥ 1.
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req_valid`  input  1  target mode offered.
- `req_ready`  output  1  high only in IDLE.
- `req_mode`  input  WIDTH  target mode; sampled only on acceptance.
- `key`  output  WIDTH  registered key pulses to the mode register.
- `cur_mode`  output  WIDTH  shadow of the downstream mode.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when the request completes.

## Operation
- Reset values: `key`=0, `cur_mode`=0, `req_ready`=1, `busy`=0, `done`=0, state IDLE.
- The downstream mode register must be reset to 0 together with this block.
- States:
  - IDLE: request accepted when `req_valid && req_ready`. Latch `diff = req_mode ^ cur_mode` into a pending mask. If `diff`=0, go to DONE; else go to PRESS.
  - PRESS: drive `key[i]`=1, where i is the lowest set bit of the pending mask. Toggle `cur_mode[i]` on entry. Stay PULSE_CYCLES cycles, then go to GAP.
  - GAP: `key`=0 for GAP_CYCLES cycles. Clear bit i from the pending mask. If the mask is non-zero, go to PRESS; else go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Only one key bit is high at a time; bits are served LSB first.
- `req_mode` and `req_valid` are ignored while `busy`.
- The cycle counter is $clog2(max(PULSE_CYCLES, GAP_CYCLES)) + 1 bits and reloads on every state entry.
- Reset mid-operation: `key` drops to 0 asynchronously, `cur_mode`=0, the pending mask is cleared, and the state returns to IDLE. There is no retry.

## Timing
- Request accepted at edge T.
- The first pulse is high for cycles T+1 … T+PULSE_CYCLES.
- Each key bit to flip costs PULSE_CYCLES+GAP_CYCLES cycles.
- With n flipped bits, `done` is high in cycle T+1+n·(PULSE_CYCLES+GAP_CYCLES).
- When `diff`=0, `done` is high at T+1.
- `req_ready` returns high in the cycle after `done`.
- `cur_mode` changes in the same cycle the matching key bit rises.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MODE_KEY_DRIVER_PARALLEL_EN` defined: all differing bits are pressed together in a single PRESS/GAP pair.
  - `key` equals `diff` during PRESS.
  - `cur_mode` is loaded with `req_mode` on PRESS entry.
  - Latency is always 1+(PULSE_CYCLES+GAP_CYCLES) when `diff`≠0.
- Undefined: serial LSB-first behaviour as described above.

## Test plan
Defaults used: WIDTH=2, PULSE=4, GAP=4.
- Reset: assert `rst` → `key`=00, `cur_mode`=00, `req_ready`=1, `busy`=0, `done`=0.
- From mode 00, request 01 at T → `key`=01 for T+1..T+4, `key`=00 for T+5..T+8, `done` at T+9, `cur_mode`=01 from T+1, `req_ready`=1 at T+10.
- From mode 01, request 10 (`diff`=11) → `key`=01 for T+1..T+4, gap, `key`=10 for T+9..T+12, gap, `done` at T+17, `cur_mode`=10.
- Request equal to `cur_mode`, plus a `req_mode` change while busy → `done` at T+1, `key` stays 00; the busy-time change is ignored.
- Assert `rst` at T+2 during a pulse → `key`=00 immediately (before the next edge), `cur_mode`=00, `req_ready`=1.
- With `MODE_KEY_DRIVER_PARALLEL_EN`, 00 → 11 → `key`=11 for T+1..T+4, `done` at T+9, `cur_mode`=11.

Source files
------------

// File: rtl/mode_key_driver.sv
// mode_key_driver
// Emits one clean key pulse per mode bit that must flip so that a downstream
// toggle-per-press mode register reaches the requested mode. A shadow copy of
// the downstream mode is kept in cur_mode.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_mode is sampled only on that edge, and
// req_ready is high only while the block is idle.
//
// Optional feature macro: MODE_KEY_DRIVER_PARALLEL_EN
//   defined   -> all differing bits are pressed together in one PRESS/GAP pair
//   undefined -> bits are pressed one at a time, LSB first
module mode_key_driver #(
    parameter int WIDTH        = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_mode,
    output logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] cur_mode,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    // Counters count down to zero, so a phase of N cycles loads N-1.
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] cur_mode_q, cur_mode_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    // Bits to press next: lowest pending bit, or every pending bit in parallel mode.
    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] pending);
`ifdef MODE_KEY_DRIVER_PARALLEL_EN
        return pending;
`else
        return pending & (~pending + WIDTH'(1));
`endif
    endfunction

    // State, datapath and registered outputs; reset drops key at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            sel_q      <= '0;
            cur_mode_q <= '0;
            key_q      <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            cur_mode_q <= cur_mode_d;
            key_q      <= key_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next state, phase counter, pending mask and shadow mode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        sel_d      = sel_q;
        cur_mode_d = cur_mode_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    mask_d = req_mode ^ cur_mode_q;
                    if (mask_d == '0) begin
                        state_d = S_DONE;
                        sel_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d    = S_PRESS;
                        sel_d      = pick(mask_d);
                        // Shadow flips in the same cycle the key rises.
                        cur_mode_d = cur_mode_q ^ sel_d;
                        cnt_d      = PULSE_LOAD;
                    end
                end
            end
            S_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    mask_d = mask_q & ~sel_q;
                    if (mask_d == '0) begin
                        state_d = S_DONE;
                        sel_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d    = S_PRESS;
                        sel_d      = pick(mask_d);
                        cur_mode_d = cur_mode_q ^ sel_d;
                        cnt_d      = PULSE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                mask_d  = '0;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so they can be registered.
    always_comb begin
        key_d   = '0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_PRESS: key_d = sel_d;
            S_DONE:  done_d = 1'b1;
            default: key_d = '0;
        endcase
    end

    assign key       = key_q;
    assign cur_mode  = cur_mode_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mode_key_driver.sv
// Testbench for mode_key_driver: randomized mode requests checked cycle by
// cycle against a reference model that expands each request into its expected
// key/mode/done timeline.
module tb_mode_key_driver;

    localparam int W = 2;
    localparam int P = 4;
    localparam int G = 4;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_mode;
    logic [W-1:0] key;
    logic [W-1:0] cur_mode;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // Expected per-cycle record, packed as {key, cur_mode, done}.
    logic [2*W:0] exp_q[$];
    logic [W-1:0] model_mode;
    logic [W-1:0] last_mode;

    mode_key_driver #(.WIDTH(W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .key       (key),
        .cur_mode  (cur_mode),
        .busy      (busy),
        .done      (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expand a request into the cycles T+1 .. done.
    task automatic push_request(input logic [W-1:0] target);
        logic [W-1:0] diff;
        logic [W-1:0] one_hot;
        diff = model_mode ^ target;
`ifdef MODE_KEY_DRIVER_PARALLEL_EN
        if (diff != '0) begin
            model_mode = target;
            for (int c = 0; c < P; c++) exp_q.push_back({diff, model_mode, 1'b0});
            for (int c = 0; c < G; c++) exp_q.push_back({{W{1'b0}}, model_mode, 1'b0});
        end
        one_hot = '0;
`else
        for (int i = 0; i < W; i++) begin
            if (diff[i]) begin
                one_hot    = '0;
                one_hot[i] = 1'b1;
                model_mode = model_mode ^ one_hot;
                for (int c = 0; c < P; c++) exp_q.push_back({one_hot, model_mode, 1'b0});
                for (int c = 0; c < G; c++) exp_q.push_back({{W{1'b0}}, model_mode, 1'b0});
            end
        end
`endif
        exp_q.push_back({{W{1'b0}}, model_mode, 1'b1});
    endtask

    // Driver: wait (bounded) for ready, then offer one request. Drives junk
    // on req_mode/req_valid in the cycle after acceptance, which must be ignored.
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL wait_ready: req_ready still %b after %0d cycles", req_ready, n);
        end
    endtask

    task automatic send(input logic [W-1:0] target);
        wait_ready();
        push_request(target);
        req_mode  = target;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_mode  = W'($urandom);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_mode  = W'($urandom);
    endtask

    // Monitor: every cycle the DUT is busy or signalling done consumes one
    // expected record; idle cycles must show a quiet, ready interface.
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (rst) begin
            last_mode = '0;
        end else if (busy || done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: busy=%b done=%b key=%0h with nothing expected at %0t",
                         busy, done, key, $time);
            end else begin
                e = exp_q.pop_front();
                last_mode = e[W:1];
                check("key", 32'(key), 32'(e[2*W:W+1]));
                check("cur_mode", 32'(cur_mode), 32'(e[W:1]));
                check("done", 32'(done), 32'(e[0]));
                check("busy_active", 32'(busy), 32'd1);
                check("ready_active", 32'(req_ready), 32'd0);
            end
        end else begin
            check("idle_key", 32'(key), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd1);
            check("idle_cur_mode", 32'(cur_mode), 32'(last_mode));
            if (exp_q.size() != 0 && !req_valid) begin
                total++;
                bad++;
                $display("FAIL missing_output: idle with %0d expected cycles pending at %0t",
                         exp_q.size(), $time);
            end
        end
    end

    // Stimulus
    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_mode   = '0;
        model_mode = '0;
        last_mode  = '0;
        #2 rst = 1'b1;
        #2;
        check("reset_key", 32'(key), 32'd0);
        check("reset_cur_mode", 32'(cur_mode), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: single flip, two flips, no flip (with junk while busy)
        send(2'b01);
        send(2'b10);
        send(2'b10);

        // Directed: reset during the first pulse
        send(2'b11);
        #1 rst = 1'b1;
        #1;
        check("midrst_key", 32'(key), 32'd0);
        check("midrst_cur_mode", 32'(cur_mode), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        model_mode = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Random requests, including repeats of the current mode
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            send(W'($urandom_range(0, (1 << W) - 1)));
        end

        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("final_cur_mode", 32'(cur_mode), 32'(model_mode));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
